flash_read: RTL
===============

Name: flash_read

Overview:
- SPI master that issues M25P16 READ DATA (0x03) with a 24-bit address and shifts in a programmable number of bytes on MISO.
- Each received byte is presented as a parallel strobe.
- Sits alongside the sector-erase and page-program controllers on the same flash bus (sck/cs_n/MOSI). It consumes the flash contents those stages produce, e.g. for erase/program read-back verification.
- Mode 0 SPI, MSB first; sck = sys_clk / CLK_DIV (12.5 MHz at 50 MHz sys_clk).

Parameters:
- CLK_DIV, 4, sys_clk cycles per sck period; even, >= 2.
- GAP_CYC, 5, sys_clk cycles cs_n held high after a transaction before done (>= tSHSL 100 ns).

Ports:
- sys_clk   in   1   system clock, 50 MHz
- rst       in   1   synchronous reset, active-high
- start     in   1   one-cycle request pulse; sampled only when busy=0
- rd_addr   in   24  flash start byte address; latched on accepted start
- rd_len    in   8   byte count; latched on accepted start; 0 means 256
- MISO      in   1   serial data from flash
- MOSI      out  1   serial command/address to flash
- cs_n      out  1   flash chip select, active-low
- sck       out  1   serial clock
- rd_data   out  8   received byte; valid only while rd_valid=1
- rd_valid  out  1   one-cycle strobe per received byte
- busy      out  1   high from the cycle after start is accepted until done
- done      out  1   one-cycle pulse at end of transaction

Behaviour:
- Clock and reset:
  - One clock domain (sys_clk). All registers update on the rising edge.
  - rst=1 forces, at the next edge: state IDLE, cs_n=1, sck=0, MOSI=0, rd_data=0, rd_valid=0, busy=0, done=0, all counters 0.
- Reset mid-transaction: the transaction is abandoned, no done pulse, and cs_n rises at that edge.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - IDLE: cs_n=1, sck=0. On start=1, latch rd_addr and rd_len, load the 32-bit shift register {8'h03, rd_addr}, and go to SETUP. Set busy=1 and cs_n=0 at the same edge.
  - SETUP: CLK_DIV cycles, sck=0, MOSI = bit 31 (command MSB), then go to SHIFT.
  - SHIFT: runs for 32 + 8*N bits, N = rd_len (0 -> 256).
  - HOLD: CLK_DIV cycles, sck=0, cs_n=0.
  - GAP: cs_n=1 for GAP_CYC cycles. On the last GAP cycle, done=1 and busy=0 at the next edge.
- SHIFT timing:
  - Phase counter p runs 0..CLK_DIV-1 per bit.
  - sck=0 for p < CLK_DIV/2 and sck=1 otherwise; sck rises when p goes CLK_DIV/2-1 -> CLK_DIV/2.
  - MOSI changes only at p=0 (sck low). After the 32 command/address bits, MOSI=0.
  - MISO is sampled on the edge where sck rises, only during the data bits (bit index >= 32), and shifted into the byte register MSB first.
- Byte output:
  - After the 8th sampled bit of each byte, rd_data is updated and rd_valid=1 for exactly one cycle.
  - rd_valid pulses are spaced 8*CLK_DIV cycles apart.
- Latency: done asserts exactly 1 + CLK_DIV*(2 + 32 + 8*N) + GAP_CYC cycles after the cycle in which start was sampled. With defaults and N=1, that is 174 cycles.
- Input handling while active:
  - start while busy=1 (including during GAP) is ignored, with no queuing.
  - rd_addr and rd_len changes after acceptance have no effect.
- Address wrap: the flash auto-increments the address. Crossing 0x1FFFFF wraps to 0x000000 inside the flash; the block takes no action.
- Output integrity: outputs are registered; no glitches on cs_n or sck. sck is always 0 while cs_n=1.

Test Plan:
- Reset: hold rst=1 for 3 cycles mid-SHIFT -> cs_n=1, sck=0, busy=0 on the next edge; no done and no further rd_valid.
- Single-byte read: rd_addr=0x000010, rd_len=1, flash initfile byte 0x10=0xA5 -> MOSI carries 0x03,0x00,0x00,0x10 MSB first; one rd_valid with rd_data=0xA5; done exactly 174 cycles after start.
- Erase verify: run sector erase on sector 0, then read rd_addr=0x000000, rd_len=16 -> 16 rd_valid strobes, each 0xFF, spaced 32 cycles apart.
- Full 256-byte read: rd_len=0 -> exactly 256 rd_valid pulses; done at 1+4*(34+2048)+5 = 8334 cycles.
- Start while busy: second start pulse 800 ns after the first, and another during GAP -> both ignored; exactly one done, byte count unchanged.
- Back-to-back: start in the cycle after done -> accepted; cs_n was high for >= GAP_CYC cycles (100 ns) between the transactions.

Source files
------------

// File: rtl/flash_read.sv
// SPI mode-0 master issuing M25P16 READ DATA (0x03) + 24-bit address, then
// shifting in a programmable number of bytes and strobing each one out.
module flash_read #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 5
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] rd_addr,
  input  logic [7:0]  rd_len,
  input  logic        MISO,
  output logic        MOSI,
  output logic        cs_n,
  output logic        sck,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done
);

  localparam int unsigned HALF    = CLK_DIV / 2;
  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = 12;
  localparam int unsigned CMD_BITS = 32;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BIT_W-1:0]   last_q, last_d;
  logic [31:0]        sr_q, sr_d;
  logic [6:0]         byte_q, byte_d;
  logic [8:0]         len_c;
  logic               mosi_d, cs_n_d, sck_d, rd_valid_d, busy_d, done_d;
  logic [7:0]         rd_data_d;

  // rd_len of 0 encodes a full 256-byte page
  assign len_c = (rd_len == 8'd0) ? 9'd256 : {1'b0, rd_len};

  // State register and all registered outputs
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      last_q   <= '0;
      sr_q     <= '0;
      byte_q   <= '0;
      MOSI     <= 1'b0;
      cs_n     <= 1'b1;
      sck      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      last_q   <= last_d;
      sr_q     <= sr_d;
      byte_q   <= byte_d;
      MOSI     <= mosi_d;
      cs_n     <= cs_n_d;
      sck      <= sck_d;
      rd_data  <= rd_data_d;
      rd_valid <= rd_valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    last_d     = last_q;
    sr_d       = sr_q;
    byte_d     = byte_q;
    rd_data_d  = rd_data;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          last_d  = BIT_W'(CMD_BITS - 1) + BIT_W'({len_c, 3'b000});
          sr_d    = {8'h03, rd_addr};
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // MISO is captured on the edge where sck rises, data bits only
        if (cnt_q == CNT_W'(HALF - 1) && bit_q >= BIT_W'(CMD_BITS)) begin
          byte_d = {byte_q[5:0], MISO};
          if (bit_q[2:0] == 3'd7) begin
            rd_data_d  = {byte_q, MISO};
            rd_valid_d = 1'b1;
          end
        end
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          sr_d  = {sr_q[30:0], 1'b0};
          if (bit_q == last_q) begin
            state_d = HOLD;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins follow the next state so they change on the same edge as the FSM
    busy_d = (state_d != IDLE);
    cs_n_d = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    sck_d  = (state_d == SHIFT) && (cnt_d >= CNT_W'(HALF));
    mosi_d = (state_d == SETUP || (state_d == SHIFT && bit_d < BIT_W'(CMD_BITS)))
             ? sr_d[31] : 1'b0;
  end

endmodule
